// File: rtl/muldiv_unit_pkg.sv
// Shared CPU constants: FSM state encoding, operation encoding and the
// small arithmetic helpers used by the multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Both algorithms retire one bit per cycle over a 32-bit operand.
  localparam logic [5:0] ITER_COUNT = 6'd32;

  // Magnitude of a two's complement word; 0x80000000 maps onto itself,
  // which reads correctly as the unsigned value 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    logic [31:0] r;
    if (x[31]) begin
      r = 32'd0 - x;
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Conditional two's complement negate, used for the divide sign fix-up.
  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = 32'd0 - x;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, try the subtract, keep it only
// if it does not go negative, and shift the resulting quotient bit in.
module muldiv_unit_div_step (
  input  logic [31:0] rem_in,
  input  logic [31:0] quo_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic [31:0] quo_out
);

  logic [32:0] shifted_s;
  logic [32:0] trial_s;
  logic        qbit_s;

  // Trial subtract and restore decision for a single quotient bit.
  always_comb begin
    shifted_s = {rem_in, quo_in[31]};
    trial_s   = shifted_s - {1'b0, divisor};
    if (!trial_s[32]) begin
      rem_out = trial_s[31:0];
      qbit_s  = 1'b1;
    end else begin
      rem_out = shifted_s[31:0];
      qbit_s  = 1'b0;
    end
    quo_out = {quo_in[30:0], qbit_s};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and signed 32/32
// restoring divide sharing one working register set. Results land in
// hi/lo only on a completed operation; a reset mid-operation discards it.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import muldiv_unit_pkg::*;

  md_state_e   state_r;
  md_state_e   state_nxt_s;
  logic [5:0]  cnt_r;
  logic [5:0]  cnt_inc_s;
  logic        last_iter_s;
  logic        op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        div_by_zero_s;

  // Working set: acc_r is the Booth accumulator (33 bits so that
  // subtracting -2^31 cannot overflow) or the division remainder,
  // work_r is the multiplier or the dividend/quotient shift register.
  logic [32:0] acc_r;
  logic [31:0] work_r;
  logic        q1_r;

  logic [32:0] m_ext_s;
  logic [32:0] booth_sum_s;
  logic [32:0] booth_acc_s;
  logic [31:0] booth_work_s;
  logic        booth_q1_s;

  logic [31:0] divisor_mag_s;
  logic [31:0] div_rem_s;
  logic [31:0] div_quo_s;
  logic [31:0] quo_signed_s;
  logic [31:0] rem_signed_s;

  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;
  logic        div_zero_r;
  logic        busy_nxt_s;
  logic        done_nxt_s;
  logic        div_zero_nxt_s;

  assign cnt_inc_s     = cnt_r + 6'd1;
  assign last_iter_s   = (cnt_inc_s == ITER_COUNT);
  assign div_by_zero_s = (b_r == 32'd0);
  assign divisor_mag_s = abs32(b_r);
  assign m_ext_s       = {a_r[31], a_r};

  muldiv_unit_div_step u_div_step (
    .rem_in  (acc_r[31:0]),
    .quo_in  (work_r),
    .divisor (divisor_mag_s),
    .rem_out (div_rem_s),
    .quo_out (div_quo_s)
  );

  // Quotient is negative when operand signs differ; remainder follows the dividend.
  always_comb begin
    quo_signed_s = neg_if(div_quo_s, a_r[31] ^ b_r[31]);
    rem_signed_s = neg_if(div_rem_s, a_r[31]);
  end

  // Booth step: add/subtract the multiplicand by {Q0, Q-1}, then arithmetic shift right.
  always_comb begin
    booth_sum_s = acc_r;
    case ({work_r[0], q1_r})
      2'b01:   booth_sum_s = acc_r + m_ext_s;
      2'b10:   booth_sum_s = acc_r - m_ext_s;
      default: booth_sum_s = acc_r;
    endcase
    {booth_acc_s, booth_work_s, booth_q1_s} = {booth_sum_s[32], booth_sum_s, work_r};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = (op == OP_DIV) ? ST_DIV : ST_MULT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MULT: begin
        if (last_iter_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_MULT;
        end
      end
      ST_DIV: begin
        if (div_by_zero_s || last_iter_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode, evaluated on the next state so the flags can be registered.
  always_comb begin
    busy_nxt_s     = (state_nxt_s == ST_MULT) || (state_nxt_s == ST_DIV);
    done_nxt_s     = (state_nxt_s == ST_DONE);
    div_zero_nxt_s = (state_r == ST_DIV) && (op_r == OP_DIV) && div_by_zero_s;
  end

  // Registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      div_zero_r <= div_zero_nxt_s;
    end
  end

  // Operand capture, iteration datapath and result write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= 6'd0;
      op_r   <= 1'b0;
      a_r    <= 32'd0;
      b_r    <= 32'd0;
      acc_r  <= 33'd0;
      work_r <= 32'd0;
      q1_r   <= 1'b0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r   <= op;
            a_r    <= a;
            b_r    <= b;
            cnt_r  <= 6'd0;
            acc_r  <= 33'd0;
            q1_r   <= 1'b0;
            work_r <= (op == OP_DIV) ? abs32(a) : b;
          end
        end
        ST_MULT: begin
          acc_r  <= booth_acc_s;
          work_r <= booth_work_s;
          q1_r   <= booth_q1_s;
          cnt_r  <= cnt_inc_s;
          if (last_iter_s) begin
            hi_r <= booth_acc_s[31:0];
            lo_r <= booth_work_s;
          end
        end
        ST_DIV: begin
          if (!div_by_zero_s) begin
            acc_r  <= {1'b0, div_rem_s};
            work_r <= div_quo_s;
            cnt_r  <= cnt_inc_s;
            if (last_iter_s) begin
              hi_r <= rem_signed_s;
              lo_r <= quo_signed_s;
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes hand-computed
// results when a start is accepted; a monitor pops and compares on done.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          busy_cycles;
    int          start_cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (busy && done) chk("busy_and_done", 64'd1, 64'd0);
      if (div_zero && !done) chk("div_zero_without_done", 64'd1, 64'd0);
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, ".hi"}, {32'd0, hi}, {32'd0, e.hi});
          chk({e.name, ".lo"}, {32'd0, lo}, {32'd0, e.lo});
          chk({e.name, ".div_zero"}, {63'd0, div_zero}, {63'd0, e.dz});
          chk({e.name, ".latency"}, 64'(cyc - e.start_cyc), 64'(e.lat));
          chk({e.name, ".busy_cycles"}, 64'(busy_cnt), 64'(e.busy_cycles));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !done) break;
      n++;
      if (n > 200) begin
        chk("wait_idle_timeout", 64'd1, 64'd0);
        exp_q.delete();
        break;
      end
    end
  endtask

  task automatic issue(input string name, input logic o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz);
    exp_t e;
    wait_idle();
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(posedge clk);
    #1;
    e.hi          = eh;
    e.lo          = el;
    e.dz          = edz;
    e.lat         = edz ? 1 : 32;
    e.busy_cycles = edz ? 1 : 32;
    e.start_cyc   = cyc;
    e.name        = name;
    exp_q.push_back(e);
    start = 1'b0;
    op    = 1'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.done", {63'd0, done}, 64'd0);
    chk("reset.div_zero", {63'd0, div_zero}, 64'd0);
    chk("reset.hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    issue("mult_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    issue("mult_min_min", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    issue("mult_max_max", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0);
    issue("mult_m1_m1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
    issue("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    issue("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    issue("div_100_7", 1'b1, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0);
    issue("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0);
    // 0x66 * 0x2AAAAAAB = 0x11_00000022, preloading hi/lo for the next case.
    issue("mult_preload", 1'b0, 32'h00000066, 32'h2AAAAAAB, 32'h00000011, 32'h00000022, 1'b0);
    issue("div_by_zero", 1'b1, 32'd5, 32'd0, 32'h00000011, 32'h00000022, 1'b1);
    issue("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

    // Abort a MULT 3x4 at iteration 10 while start is toggled during busy.
    wait_idle();
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd3;
    b     = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd9;
    b     = 32'd0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    chk("abort.busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("abort.busy", {63'd0, busy}, 64'd0);
    chk("abort.done", {63'd0, done}, 64'd0);
    chk("abort.div_zero", {63'd0, div_zero}, 64'd0);
    chk("abort.hilo", {hi, lo}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort.idle_busy", {63'd0, busy}, 64'd0);
    chk("abort.idle_hilo", {hi, lo}, 64'd0);

    issue("mult_3_4", 1'b0, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 1'b0);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low reset; asserted (0) forces reset state immediately.
REQ-003 SHALL provide: start  in  1  request pulse from control unit; sampled only in IDLE.
REQ-004 SHALL provide: op  in  1  0 = MULT, 1 = DIV; sampled with start.
REQ-005 SHALL provide: a  in  32  operand rs (multiplicand / dividend), signed two's complement.
REQ-006 SHALL provide: b  in  32  operand rt (multiplier / divisor), signed two's complement.
REQ-007 SHALL provide: busy  out  1  high while an operation iterates (MULT or DIV state).
REQ-008 SHALL provide: done  out  1  one-cycle completion pulse (DONE state).
REQ-009 SHALL provide: div_zero  out  1  high with done when a DIV had b == 0; low otherwise.
REQ-010 SHALL provide: hi  out  32  HI register (product upper word / remainder).
REQ-011 SHALL provide: lo  out  32  LO register (product lower word / quotient).

Function
REQ-012 SHALL implement FSM states IDLE, MULT, DIV, DONE; IDLE is the reset state.
REQ-013 In IDLE, start=1 at an edge (E0) SHALL latch a, b, op, clear the iteration counter and go to MULT (op=0) or DIV (op=1); start=1 outside IDLE SHALL be ignored.
REQ-014 MULT SHALL be signed radix-2 Booth, one iteration per edge; the 32nd iteration occurs at E32, writing the 64-bit product to hi:lo and entering DONE.
REQ-015 DIV SHALL be a 32-iteration restoring divide on magnitudes, one iteration per edge; at E32 it SHALL write quotient to lo and remainder to hi, then enter DONE.
REQ-016 DIV sign rules: quotient truncates toward zero; remainder takes the dividend's sign; 0x80000000 / -1 SHALL yield lo=0x80000000, hi=0 (wrap, no flag).
REQ-017 DIV with latched b == 0 SHALL skip iteration and enter DONE at E1 with div_zero=1; hi and lo SHALL remain unchanged.
REQ-018 DONE SHALL last exactly one cycle (done=1), then return to IDLE; a new start is accepted from the following IDLE cycle onward.
REQ-019 Latency: done is high in the cycle after E32 (33 cycles after the start edge), or in the cycle after E1 for divide-by-zero.
REQ-020 busy SHALL equal 1 exactly in MULT and DIV states; busy and done SHALL never be high together.
REQ-021 hi and lo SHALL hold their values until the next successful completion; operand changes after E0 SHALL not affect the result.
REQ-022 div_zero SHALL be 0 in every state except DONE following a divide-by-zero.

Reset
REQ-023 On reset=0, regardless of state: state=IDLE, counter=0, busy=0, done=0, div_zero=0, hi=0, lo=0, internal operand registers cleared.
REQ-024 Reset asserted mid-operation SHALL abort it with no partial write to hi/lo; no done SHALL be produced for the aborted operation.
REQ-025 After reset release, the first start SHALL be accepted on the first rising edge with start=1.

Structure
REQ-026 FSM state encodings and op encodings (MULT=0, DIV=1) SHALL live in the shared CPU constants package used by ctrl_unit.
REQ-027 One combinational sub-module, div_step (one restoring subtract/shift iteration), is natural; Booth step stays inline.
REQ-028 The iteration counter SHALL be 6 bits, compared against 32 for termination.

Verification
REQ-029 MULT a=7, b=-3 -> 33 cycles later done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high cycles 1..32.
REQ-030 MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-031 DIV a=7, b=-2 -> lo=0xFFFFFFFD, hi=0x00000001; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 DIV a=5, b=0 with hi/lo preloaded 0x11/0x22 -> done and div_zero high one cycle after start edge, hi=0x11, lo=0x22.
REQ-033 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-034 Reset asserted at iteration 10 of MULT 3x4, start toggled while busy -> all outputs 0 immediately, no done; next MULT 3x4 gives lo=12, hi=0.
